// File: rtl/lander_touchdown_judge.sv
// lander_touchdown_judge
//   Downstream judge for the lunar-lander counter block. Tracks flight phase,
//   latches the touchdown velocity, classifies the landing (soft/hard/crash),
//   keeps flight statistics and drives a 7-segment status glyph.
//
// Ports
//   clk_2          clock, all state updates on the rising edge
//   reset          synchronous, active-high
//   i_fuel         fuel counter from the lander stage
//   i_velo         signed velocity (two's complement), negative = descending
//   i_alt          unsigned altitude
//   o_state        phase: 0 FLYING, 1 EMPTY, 2 SOFT, 3 HARD, 4 CRASH
//   o_flight_time  cycles airborne, saturating
//   o_touch_velo   signed velocity latched at touchdown
//   o_max_descent  largest descent-speed magnitude seen (unsigned)
//   o_seg          status glyph {g,f,e,d,c,b,a}, active-high
//   o_done         high in SOFT, HARD or CRASH
//
// Build option
//   LANDER_FUEL_WARN_EN  blink an 'L' on the glyph while flying on low fuel.
//
// State table
//   FLYING | airborne with fuel
//   EMPTY  | airborne, fuel exhausted (only reset refills)
//   SOFT   | landed, |v| <= SAFE_VELO
//   HARD   | landed, |v| <= HARD_VELO
//   CRASH  | landed faster than HARD_VELO
module lander_touchdown_judge #(
  parameter int NBITS_COMB = 8,
  parameter int NBITS_VELO = 12,
  parameter int NBITS_ALT  = 12,
  parameter int NBITS_TIME = 8,
  parameter int SAFE_VELO  = 10,
`ifdef LANDER_FUEL_WARN_EN
  parameter int FUEL_LOW   = 20,
`endif
  parameter int HARD_VELO  = 25
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic [NBITS_COMB-1:0] i_fuel,
  input  logic [NBITS_VELO-1:0] i_velo,
  input  logic [NBITS_ALT-1:0]  i_alt,
  output logic [2:0]            o_state,
  output logic [NBITS_TIME-1:0] o_flight_time,
  output logic [NBITS_VELO-1:0] o_touch_velo,
  output logic [NBITS_VELO-1:0] o_max_descent,
  output logic [6:0]            o_seg,
  output logic                  o_done
);

  localparam logic [2:0] ST_FLYING = 3'd0;
  localparam logic [2:0] ST_EMPTY  = 3'd1;
  localparam logic [2:0] ST_SOFT   = 3'd2;
  localparam logic [2:0] ST_HARD   = 3'd3;
  localparam logic [2:0] ST_CRASH  = 3'd4;

  localparam logic [NBITS_VELO:0] LP_SAFE = (NBITS_VELO+1)'(SAFE_VELO);
  localparam logic [NBITS_VELO:0] LP_HARD = (NBITS_VELO+1)'(HARD_VELO);

  logic [2:0]            r_state;
  logic [NBITS_TIME-1:0] r_flight_time;
  logic [NBITS_VELO-1:0] r_touch_velo;
  logic [NBITS_VELO-1:0] r_max_descent;
  logic                  r_done;
  logic [NBITS_VELO-1:0] r_velo_q;
  logic                  r_blink;

  logic                  w_airborne;
  logic [NBITS_VELO:0]   w_velo_q_ext;
  logic [NBITS_VELO:0]   w_mag;
  logic [NBITS_VELO-1:0] w_descent;

  assign w_airborne   = (r_state == ST_FLYING) || (r_state == ST_EMPTY);
  // One extra bit so the most negative velocity has a representable magnitude.
  assign w_velo_q_ext = {r_velo_q[NBITS_VELO-1], r_velo_q};
  assign w_mag        = r_velo_q[NBITS_VELO-1] ? (~w_velo_q_ext + 1'b1) : w_velo_q_ext;
  // Only used when i_velo is negative; the N-bit unsigned result is exact then.
  assign w_descent    = ~i_velo + 1'b1;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state       <= ST_FLYING;
      r_flight_time <= '0;
      r_touch_velo  <= '0;
      r_max_descent <= '0;
      r_done        <= 1'b0;
      r_velo_q      <= '0;
    end else if (w_airborne) begin
      // alt on this edge was produced by last cycle's velocity, hence velo_q.
      r_velo_q <= i_velo;
      if (r_flight_time != '1)
        r_flight_time <= r_flight_time + NBITS_TIME'(1);
      if (i_velo[NBITS_VELO-1] && (w_descent > r_max_descent))
        r_max_descent <= w_descent;
      if (i_alt == '0) begin
        r_touch_velo <= r_velo_q;
        r_done       <= 1'b1;
        if (w_mag <= LP_SAFE)
          r_state <= ST_SOFT;
        else if (w_mag <= LP_HARD)
          r_state <= ST_HARD;
        else
          r_state <= ST_CRASH;
      end else if ((r_state == ST_FLYING) && (i_fuel == '0)) begin
        r_state <= ST_EMPTY;
      end
    end
  end

`ifdef LANDER_FUEL_WARN_EN
  always_ff @(posedge clk_2) begin
    if (reset)
      r_blink <= 1'b0;
    else if ((r_state == ST_FLYING) && (i_fuel != '0) && (i_fuel < NBITS_COMB'(FUEL_LOW)))
      r_blink <= ~r_blink;
    else
      r_blink <= 1'b0;
  end
`else
  assign r_blink = 1'b0;
`endif

  always_comb begin
    o_seg = 7'h40;
    case (r_state)
      ST_FLYING: o_seg = r_blink ? 7'h38 : 7'h40;
      ST_EMPTY:  o_seg = 7'h79;
      ST_SOFT:   o_seg = 7'h6D;
      ST_HARD:   o_seg = 7'h76;
      ST_CRASH:  o_seg = 7'h39;
      default:   o_seg = 7'h40;
    endcase
  end

  assign o_state       = r_state;
  assign o_flight_time = r_flight_time;
  assign o_touch_velo  = r_touch_velo;
  assign o_max_descent = r_max_descent;
  assign o_done        = r_done;

endmodule

// File: doc/lander_touchdown_judge.md
Name: lander_touchdown_judge

Overview:
- Downstream stage of the lunar-lander counter block; shares its clock.
- Consumes the fuel, velocity and altitude counters every clk_2 cycle.
- Tracks flight phase, latches touchdown velocity and classifies the landing as soft, hard or crash.
- Produces flight statistics and a 7-segment status glyph for SEG[6:0]; SEG[7] remains the clock indicator.

Parameters:
- NBITS_COMB, 8, fuel counter width.
- NBITS_VELO, 12, velocity width, two's complement.
- NBITS_ALT, 12, altitude width, unsigned.
- NBITS_TIME, 8, flight-time counter width.
- SAFE_VELO, 10, maximum touchdown speed magnitude for a soft landing.
- HARD_VELO, 25, maximum touchdown speed magnitude for a hard landing; anything above is a crash.
- FUEL_LOW, 20, low-fuel warning threshold (used only with the optional feature).

Ports:
- clk_2  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- fuel  in  NBITS_COMB  fuel counter from the lander stage.
- velo  in  NBITS_VELO  signed velocity from the lander stage; negative means descending.
- alt  in  NBITS_ALT  altitude from the lander stage.
- state  out  3  phase code: 0 FLYING, 1 EMPTY, 2 SOFT, 3 HARD, 4 CRASH.
- flight_time  out  NBITS_TIME  cycles spent airborne, saturating.
- touch_velo  out  NBITS_VELO  signed velocity latched at touchdown.
- max_descent  out  NBITS_VELO  largest descent-speed magnitude seen, unsigned.
- seg  out  7  status glyph, active-high segments {g,f,e,d,c,b,a}.
- done  out  1  high in SOFT, HARD or CRASH.

Behaviour:
- Reset:
  - Values taken on the first edge with reset=1: state=FLYING, flight_time=0, touch_velo=0, max_descent=0, done=0.
  - Internal registers cleared: velo_q=0 and blink=0.
  - Reset mid-operation, including from a terminal state, returns everything to these values on the next edge.
- velo_q:
  - Loaded with velo on every non-reset edge while in FLYING or EMPTY.
  - Holds the velocity that produced the current altitude; the upstream stage updates alt using the previous velocity.
- Touchdown:
  - Condition: alt==0 while in FLYING or EMPTY.
  - On that edge: touch_velo<=velo_q and mag=|velo_q|, computed NBITS_VELO+1 wide so -2048 gives 2048.
  - mag<=SAFE_VELO -> SOFT; mag<=HARD_VELO -> HARD; otherwise CRASH.
  - Positive velo_q is classified by magnitude in the same way.
- FLYING -> EMPTY: on an edge where fuel==0 and alt!=0.
- EMPTY never returns to FLYING; fuel is refilled only by reset.
- Simultaneous events: alt==0 together with fuel==0 takes the touchdown branch, so EMPTY is skipped.
- Terminal states SOFT, HARD and CRASH hold until reset; all outputs freeze while in them.
- flight_time: +1 on each edge spent in FLYING or EMPTY, including the touchdown edge; saturates at 2^NBITS_TIME-1.
- max_descent: in FLYING or EMPTY, if velo<0 and -velo>max_descent then max_descent<=-velo; positive velo is ignored.
- done: registered, asserted in the same edge as the terminal state is entered.
- seg: combinational from state (and blink, when the optional feature is enabled):
  - FLYING 7'h40 '-'
  - EMPTY 7'h79 'E'
  - SOFT 7'h6D 'S'
  - HARD 7'h76 'H'
  - CRASH 7'h39 'C'
- Inputs are registered outputs of the lander stage; no input synchronisation is needed.

Optional Feature:
- Macro: LANDER_FUEL_WARN_EN.
- Defined:
  - In FLYING with 0<fuel<FUEL_LOW, blink toggles every edge.
  - seg shows 7'h38 'L' when blink=1 and '-' when blink=0.
  - blink is forced to 0 outside that condition.
- Undefined: blink logic is absent and FLYING always shows 7'h40.

Test Plan:
- Reset, then fuel=120, velo=-50, alt=500 for 3 edges -> state=0, flight_time=3, max_descent=50, done=0, seg=7'h40.
- One edge with velo=-8, alt=20; then alt=0, velo=-3 -> state=2, touch_velo=12'hFF8, done=1, seg=7'h6D; further input changes leave every output frozen.
- Prior velo=-20 then alt=0 -> state=3, seg=7'h76. Prior velo=-26 then alt=0 -> state=4, seg=7'h39, touch_velo=12'hFE6.
- fuel=0, alt=100 -> state=1, seg=7'h79; then prior velo=-10, alt=0, fuel=0 -> state=2. Separately, fuel=0 and alt=0 on the same edge with prior velo=-30 -> state=4 directly.
- 300 edges of fuel=50, velo=-5, alt=400 -> flight_time stops at 255; max_descent=5.
- reset=1 for one edge while in CRASH -> state=0, flight_time=0, touch_velo=0, max_descent=0, done=0. With LANDER_FUEL_WARN_EN, fuel=10 in FLYING -> seg alternates 7'h38, 7'h40, 7'h38 on successive edges.
